// File: rtl/dmem_sram_bridge_if.sv
// -----------------------------------------------------------------------------
// dmem_sram_bridge_if
//   SRAM-like data bus between the memory-stage bridge and the data memory.
//   The bus has one request channel and one response channel.
//   master : bridge side. It drives the request and receives addr_ok/data_ok.
//   slave  : memory side.
//   Signals:
//     data_req / data_wr / data_size / data_addr / data_wdata / data_wstrb
//         request channel (master -> slave)
//     data_addr_ok  request accepted (slave -> master)
//     data_data_ok  read data valid or write complete (slave -> master)
//     data_rdata    read data (slave -> master)
// -----------------------------------------------------------------------------
interface dmem_sram_bridge_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/dmem_sram_bridge.sv
// -----------------------------------------------------------------------------
// dmem_sram_bridge
//   Memory-stage data-side bridge. It turns the M-stage load/store request into
//   one SRAM-like bus transaction and returns the raw 32-bit read word. It
//   stalls the pipeline while that transaction is outstanding. Only one
//   transaction is in flight at a time.
//
//   Ports:
//     clk, rst     clock and asynchronous active-low reset
//     m_valid      M-stage instruction is a load/store
//     m_wen        byte-lane write enables (0 = read)
//     m_size       0 byte, 1 half, 2 word
//     m_addr       virtual effective address
//     m_wdata      lane-replicated store data
//     m_hold       M stage frozen by another stall source
//     m_flush      M-stage instruction is being flushed
//     m_rdata      registered read word
//     m_stall      stall request to the hazard unit
//     bus          SRAM-like data bus (master side)
//     m_adel/m_ades  misaligned load/store flags (only with DMEM_ALIGN_CHECK_EN)
//
//   Optional feature: define DMEM_ALIGN_CHECK_EN to add the alignment check.
//   A misaligned access found in IDLE is then not issued and does not stall.
// -----------------------------------------------------------------------------
module dmem_sram_bridge #(
   parameter logic [31:0] ADDR_MASK     = 32'h1FFF_FFFF,
   parameter bit          FLUSH_ON_DONE = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     m_valid,
   input  logic [3:0]               m_wen,
   input  logic [1:0]               m_size,
   input  logic [31:0]              m_addr,
   input  logic [31:0]              m_wdata,
   input  logic                     m_hold,
   input  logic                     m_flush,
   output logic [31:0]              m_rdata,
   output logic                     m_stall,
   dmem_sram_bridge_if.master       bus
`ifdef DMEM_ALIGN_CHECK_EN
   ,
   output logic                     m_adel,
   output logic                     m_ades
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   state_e      state_q, state_d;
   logic        cancel_q, cancel_d;
   logic [31:0] rdata_q, rdata_d;

   logic v;
   logic is_read;
   logic misalign;
   logic issue;
   logic busy;
   logic complete;

   assign v       = m_valid & ~m_flush;
   assign is_read = (m_wen == 4'b0000);
   assign busy    = (state_q == S_REQ) | (state_q == S_WAIT);

`ifdef DMEM_ALIGN_CHECK_EN
   // The check uses the unmasked address. The mask only folds kseg0/kseg1.
   assign misalign = ((m_size == 2'd1) & m_addr[0]) |
                     ((m_size == 2'd2) & (m_addr[1:0] != 2'b00));
   assign m_adel   = (state_q == S_IDLE) & v & misalign & is_read;
   assign m_ades   = (state_q == S_IDLE) & v & misalign & ~is_read;
`else
   assign misalign = 1'b0;
`endif

   assign issue = (state_q == S_IDLE) & v & ~misalign;

   // The request fields come straight from the M stage. m_stall keeps them
   // stable for as long as the access is live.
   assign bus.data_req   = rst & (issue | (state_q == S_REQ));
   assign bus.data_wr    = ~is_read;
   assign bus.data_size  = m_size;
   assign bus.data_addr  = m_addr & ADDR_MASK;
   assign bus.data_wdata = m_wdata;
   assign bus.data_wstrb = m_wen;

   // A flushed instruction stops stalling at once. A younger access that
   // arrives while the cancelled transaction drains stalls through the v term.
   assign m_stall = rst & ((v & (state_q != S_DONE) & ~((state_q == S_IDLE) & misalign)) |
                           (m_valid & cancel_q & busy));

   assign m_rdata = rdata_q;

   always_comb begin
      // NOTE: every variable gets a default first, so no path can leave a latch behind.
      state_d  = state_q;
      cancel_d = cancel_q;
      rdata_d  = rdata_q;
      complete = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (issue) begin
               if (bus.data_addr_ok & bus.data_data_ok) complete = 1'b1;
               else if (bus.data_addr_ok)               state_d  = S_WAIT;
               else                                     state_d  = S_REQ;
            end
         end
         S_REQ: begin
            // The request stays up until it is accepted, even after a flush.
            if (m_flush) cancel_d = 1'b1;
            if (bus.data_addr_ok) begin
               if (bus.data_data_ok) complete = 1'b1;
               else                  state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (m_flush)           cancel_d = 1'b1;
            if (bus.data_data_ok)  complete = 1'b1;
         end
         S_DONE: begin
            // Leave DONE only once, when the held instruction moves on.
            if (~m_hold | (FLUSH_ON_DONE & m_flush)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A flush that arrives in the same cycle as the response also kills it.
      // Otherwise DONE would hold a result for an instruction that has gone.
      if (complete) begin
         if (cancel_q | m_flush) begin
            state_d  = S_IDLE;
            cancel_d = 1'b0;
         end else begin
            state_d = S_DONE;
            if (is_read) rdata_d = bus.data_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cancel_q <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
         state_q  <= state_d;
         cancel_q <= cancel_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule
